// File: rtl/out_arbiter.sv
// Two-source output arbiter with a registered output stage: round-robin with bounded bursts,
// or strict source-0 priority when OUT_ARB_FIXED_PRIO_EN is defined.
module out_arbiter #(
  parameter int TAG_WIDTH   = 32,
  parameter int BLOCKLENGTH = 1,
  parameter int DATA_WIDTH  = 8,
  parameter int BURST_LEN   = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              ready_in,
  input  logic                              valid_in0,
  input  logic                              valid_in1,
  input  logic [TAG_WIDTH-1:0]              tag_in0,
  input  logic [TAG_WIDTH-1:0]              tag_in1,
  input  logic [DATA_WIDTH*BLOCKLENGTH-1:0] data_in0,
  input  logic [DATA_WIDTH*BLOCKLENGTH-1:0] data_in1,
  output logic                              ready_out0,
  output logic                              ready_out1,
  output logic                              valid_out,
  output logic [TAG_WIDTH-1:0]              tag_out,
  output logic [DATA_WIDTH*BLOCKLENGTH-1:0] data_out,
  output logic                              src_out,
  output logic                              busy
);

  logic advance;
  logic grant;
  logic xfer;

  assign advance    = !valid_out || ready_in;
  assign ready_out0 = advance && !grant;
  assign ready_out1 = advance && grant;
  assign xfer       = (valid_in0 && ready_out0) || (valid_in1 && ready_out1);
  assign busy       = valid_out;

`ifdef OUT_ARB_FIXED_PRIO_EN
  assign grant = !valid_in0;
`else
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  localparam int CW = $clog2(BURST_LEN + 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          last, last_nxt;
  logic          own, v_own, v_oth, burst_left;

  // Grant depends only on registered state and current valids, never on ready_in.
  always_comb begin
    grant      = !last;
    state_nxt  = state;
    cnt_nxt    = cnt;
    last_nxt   = last;
    own        = (state == OWN1);
    v_own      = own ? valid_in1 : valid_in0;
    v_oth      = own ? valid_in0 : valid_in1;
    burst_left = (cnt < CW'(BURST_LEN));

    if (state == IDLE) begin
      if (valid_in0 != valid_in1) grant = valid_in1;
      else                        grant = !last;
    end else if (v_own && (burst_left || !v_oth)) begin
      grant = own;
    end else if (v_oth) begin
      grant = !own;
    end else begin
      grant = own;
    end

    // With advance high, some valid source always gets a transfer, so no-xfer means both idle.
    if (advance) begin
      if (xfer) begin
        last_nxt = grant;
        if (state != IDLE && grant == own) begin
          if (burst_left) cnt_nxt = cnt + 1'b1;
        end else begin
          state_nxt = grant ? OWN1 : OWN0;
          cnt_nxt   = CW'(1);
        end
      end else begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      last  <= last_nxt;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out <= 1'b0;
      tag_out   <= '0;
      data_out  <= '0;
      src_out   <= 1'b0;
    end else if (advance) begin
      valid_out <= xfer;
      if (xfer) begin
        tag_out  <= grant ? tag_in1 : tag_in0;
        data_out <= grant ? data_in1 : data_in0;
        src_out  <= grant;
      end
    end
  end

endmodule

// File: tb/tb_out_arbiter.sv
// Bench for out_arbiter: vector table plus directed corner sequences, with a cycle model
// feeding a scoreboard queue that checks every word the DUT emits.
module tb_out_arbiter;
  localparam int BL = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        ready_in, valid_in0, valid_in1;
  logic [31:0] tag_in0, tag_in1, tag_out;
  logic [7:0]  data_in0, data_in1, data_out;
  logic        ready_out0, ready_out1, valid_out, src_out, busy;

  int n_cmp = 0;
  int n_err = 0;

  out_arbiter #(.TAG_WIDTH(32), .BLOCKLENGTH(1), .DATA_WIDTH(8), .BURST_LEN(BL)) dut (
    .clk(clk), .reset(reset), .ready_in(ready_in),
    .valid_in0(valid_in0), .valid_in1(valid_in1),
    .tag_in0(tag_in0), .tag_in1(tag_in1), .data_in0(data_in0), .data_in1(data_in1),
    .ready_out0(ready_out0), .ready_out1(ready_out1), .valid_out(valid_out),
    .tag_out(tag_out), .data_out(data_out), .src_out(src_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard (evaluated at negedge) ----------------
  typedef struct packed {
    logic [31:0] tag;
    logic [7:0]  data;
    logic        src;
  } item_t;

  item_t q[$];
  item_t held;
  bit    armed = 0, m_valid, m_loaded, m_zero, m_last;
  int    m_st, m_cnt;

  always @(negedge clk) begin
    bit adv, g, o, mine, theirs, x;
    if (armed) begin
      chk("valid_out", valid_out, m_valid);
      chk("busy", busy, m_valid);
      if (m_loaded) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL scoreboard_empty: got new word expected none at %0t", $time);
        end else held = q.pop_front();
      end
      if (m_valid || m_zero) begin
        chk("tag_out", tag_out, held.tag);
        chk("data_out", data_out, held.data);
        chk("src_out", src_out, held.src);
      end
    end
    if (reset) begin
      m_valid = 0; m_loaded = 0; m_zero = 1; m_st = 0; m_cnt = 0; m_last = 1;
      held = '0; q.delete(); armed = 1;
    end else if (armed) begin
      adv = !m_valid || ready_in;
      o   = (m_st == 2);
`ifdef OUT_ARB_FIXED_PRIO_EN
      g = !valid_in0;
`else
      if (m_st == 0) begin
        if (valid_in0 && !valid_in1)      g = 0;
        else if (valid_in1 && !valid_in0) g = 1;
        else                              g = !m_last;
      end else begin
        mine   = o ? valid_in1 : valid_in0;
        theirs = o ? valid_in0 : valid_in1;
        if (mine && (m_cnt < BL || !theirs)) g = o;
        else if (theirs)                     g = !o;
        else                                 g = o;
      end
`endif
      chk("ready_out0", ready_out0, adv && !g);
      chk("ready_out1", ready_out1, adv && g);
      x = adv && (g ? valid_in1 : valid_in0);
      m_loaded = 0;
      if (adv) begin
        if (x) begin
          q.push_back(g ? item_t'{tag_in1, data_in1, 1'b1} : item_t'{tag_in0, data_in0, 1'b0});
          m_loaded = 1; m_valid = 1; m_zero = 0;
          if (m_st != 0 && g == o) m_cnt = (m_cnt < BL) ? m_cnt + 1 : BL;
          else begin m_st = g ? 2 : 1; m_cnt = 1; end
          m_last = g;
        end else begin
          m_valid = 0; m_st = 0; m_cnt = 0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {
    bit v0, v1, rdy;
    bit ev, es;
  } vec_t;
  vec_t tbl[9];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v0, input bit v1, input bit rdy,
                       input logic [31:0] t0, input logic [31:0] t1);
    valid_in0 = v0; valid_in1 = v1; ready_in = rdy;
    tag_in0 = t0; tag_in1 = t1;
    data_in0 = t0[7:0] ^ 8'h5a; data_in1 = t1[7:0] ^ 8'ha5;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    chk("rst_valid_out", valid_out, 1'b0);
    chk("rst_tag_out", tag_out, 32'h0);
    chk("rst_src_out", src_out, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] t0_held;
    for (int i = 0; i < 9; i++) begin
      tbl[i].v0 = 1; tbl[i].v1 = 1; tbl[i].rdy = 1; tbl[i].ev = 1;
`ifdef OUT_ARB_FIXED_PRIO_EN
      tbl[i].es = 0;
`else
      tbl[i].es = (i >= 4 && i < 8);
`endif
    end

    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    do_reset();

    // single source 0 word
    drive(1, 0, 1, 32'd5, 32'd0);
    step();
    chk("s0_valid", valid_out, 1'b1);
    chk("s0_tag", tag_out, 32'd5);
    chk("s0_src", src_out, 1'b0);
    drive(0, 0, 1, 0, 0);
    do_reset();

    // both valid: burst alternation
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].v0, tbl[i].v1, tbl[i].rdy, 32'h100 + i, 32'h200 + i);
      step();
      chk($sformatf("tbl%0d_valid", i), valid_out, tbl[i].ev);
      chk($sformatf("tbl%0d_src", i), src_out, tbl[i].es);
    end

    // source 1 alone saturates its burst, then yields to source 0
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 1, 0, 32'h300 + i);
      step();
      chk($sformatf("solo1_%0d_src", i), src_out, 1'b1);
    end
    drive(1, 1, 1, 32'h400, 32'h401);
    step();
    chk("yield_src", src_out, 1'b0);
    chk("yield_tag", tag_out, 32'h400);
    t0_held = 32'h400;

    // stall with both valid
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 32'h500 + i, 32'h600 + i);
      #1;
      chk("stall_rdy0", ready_out0, 1'b0);
      chk("stall_rdy1", ready_out1, 1'b0);
      step();
      chk("stall_tag", tag_out, t0_held);
      chk("stall_src", src_out, 1'b0);
      chk("stall_valid", valid_out, 1'b1);
    end

    // reset while holding a word
    drive(1, 1, 1, 32'h700, 32'h701);
    reset = 1'b1;
    step();
    chk("midrst_valid", valid_out, 1'b0);
    chk("midrst_tag", tag_out, 32'h0);
    chk("midrst_data", data_out, 8'h0);
    reset = 1'b0;
    step();
    chk("postrst_src", src_out, 1'b0);
    chk("postrst_valid", valid_out, 1'b1);

    // random traffic, checked by the model/scoreboard
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 3) != 0), $urandom, $urandom);
      step();
    end
    drive(0, 0, 1, 0, 0);
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
